crc_encode_ctrl: RTL and testbench
==================================

CRC_ENCODE_CTRL -- requirements
Module: crc_encode_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: data width; SHALL remain 8 to match the CRC-4 encoder.
REQ-002 Parameter ADDR_W, default 4: address width; SHALL remain 4.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  2  per-requester write request.
REQ-007 req_data  in  2x8  per-requester data byte (requester i at bits [8i+7:8i]).
REQ-008 req_addr  in  2x4  per-requester address.
REQ-009 req_ready  out  2  per-requester accept; one-hot or zero.
REQ-010 req_ack  out  2  one-cycle completion pulse to the owning requester.
REQ-011 mem_we  out  1  memory write strobe.
REQ-012 mem_addr  out  4  memory address.
REQ-013 mem_wdata  out  12  codeword: {data[7:0], crc[3:0]}.
REQ-014 mem_ready  in  1  memory accepts the write this cycle.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SHIFT and WRITE.
REQ-017 In IDLE, req_ready SHALL be asserted combinationally for exactly one requester with req_valid high, chosen by round-robin; it SHALL be zero in all other states.
REQ-018 A request SHALL be accepted on the edge where req_valid[i] and req_ready[i] are both high; data, address and grant id SHALL be latched, and the FSM SHALL move to LOAD.
REQ-019 Round-robin: the pointer SHALL point to requester 0 after reset and to the other requester after each accept; on simultaneous valid, the pointed requester SHALL win.
REQ-020 A lone valid requester SHALL be granted regardless of the pointer.
REQ-021 LOAD SHALL last one cycle, driving encoder load=1 and shift_en=0 with the latched data and address.
REQ-022 SHIFT SHALL last exactly 8 cycles, driving shift_en=1 and load=0, counted by a 3-bit counter 0..7; after count 7 the FSM SHALL go to WRITE.
REQ-023 In WRITE, mem_we SHALL be 1, with mem_addr and mem_wdata taken from the encoder outputs; these SHALL stay stable while mem_ready=0.
REQ-024 On the edge where mem_we and mem_ready are both high, the FSM SHALL return to IDLE, and req_ack of the granted requester SHALL pulse high for the following single cycle.
REQ-025 Latency: the accept edge plus 10 cycles to the first possible write handshake (1 LOAD, 8 SHIFT, 1 WRITE), with no back-to-back overlap.
REQ-026 The CRC SHALL be data mod x^4+x+1 (MSB first, unaugmented), as produced by the encoder.
REQ-027 Changes on req_valid, req_data or req_addr after accept SHALL NOT affect the transaction in flight.
REQ-028 A requester whose valid is held during busy SHALL be served after the current transaction, never dropped.

Reset
REQ-029 Asserting rst at any time, including mid-SHIFT or mid-WRITE, SHALL asynchronously force IDLE, pointer=0, counter=0, latched registers=0, and req_ready=req_ack=mem_we=busy=0.
REQ-030 rst SHALL also reset the encoder instance; the in-flight transaction SHALL be discarded with no ack.
REQ-031 Operation SHALL resume on the first rising clk edge after rst is deasserted.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, DATA_W/ADDR_W/CRC_W (4) constants and SHIFT_CYCLES (8).
REQ-033 The block SHALL instantiate exactly one crc_code_encoder sub-module; the FSM, arbiter and counter SHALL live in crc_encode_ctrl.

Verification
REQ-034 Requester 0 writes data 0xA5 to address 0x3 with mem_ready=1 -> mem_we at accept+10, mem_addr=0x3, mem_wdata=0xA58, req_ack[0] pulses one cycle later.
REQ-035 Both requesters valid after reset (data 0xFF to address 0x1, data 0x10 to address 0x2) -> requester 0 first (0xFFD), then requester 1 (0x103); the pointer alternates on a repeat.
REQ-036 mem_ready held low 5 cycles in WRITE -> mem_we, mem_addr and mem_wdata stable for 6 cycles; ack only after the handshake.
REQ-037 rst pulsed at SHIFT count 4 -> all outputs 0 immediately, no ack; a following request for data 0x01 yields 0x011.
REQ-038 Requester 1 raises valid during busy and changes req_data in flight -> the in-flight codeword is unchanged, and requester 1 is accepted in the first IDLE cycle.

Source files
------------

// File: rtl/crc_encode_ctrl_pkg.sv
// crc_encode_ctrl_pkg: shared constants, FSM states and CRC-4 step helper
package crc_encode_ctrl_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int CRC_W = 4;
  localparam int CW_W = DATA_W + CRC_W;
  localparam int SHIFT_CYCLES = 8;
  localparam int CNT_W = $clog2(SHIFT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_CYCLES - 1);
  localparam logic [CRC_W-1:0] CRC_POLY = 4'h3;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WRITE} state_t;
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc, input logic bit_in);
    return {crc[CRC_W-2:0], bit_in} ^ (crc[CRC_W-1] ? CRC_POLY : '0);
  endfunction
endpackage

// File: rtl/crc_encode_ctrl_encoder.sv
// crc_code_encoder: serial MSB-first CRC-4 (x^4+x+1) encoder producing {data, crc}
import crc_encode_ctrl_pkg::*;
module crc_code_encoder (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] code_addr,
  output logic [CW_W-1:0]   codeword
);
  logic [DATA_W-1:0] data_q, sreg;
  logic [ADDR_W-1:0] addr_q;
  logic [CRC_W-1:0]  crc_q;
  // load captures the byte; each shift folds the next MSB into the remainder
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      sreg   <= '0;
      addr_q <= '0;
      crc_q  <= '0;
    end else if (load) begin
      data_q <= data;
      sreg   <= data;
      addr_q <= addr;
      crc_q  <= '0;
    end else if (shift_en) begin
      sreg  <= sreg << 1;
      crc_q <= crc_step(crc_q, sreg[DATA_W-1]);
    end
  end
  assign code_addr = addr_q;
  assign codeword  = {data_q, crc_q};
endmodule

// File: rtl/crc_encode_ctrl.sv
// crc_encode_ctrl: two-requester round-robin front end that CRC-encodes a byte and writes it to memory
import crc_encode_ctrl_pkg::*;
module crc_encode_ctrl #(
  parameter int DATA_W = crc_encode_ctrl_pkg::DATA_W,
  parameter int ADDR_W = crc_encode_ctrl_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [2*DATA_W-1:0] req_data,
  input  logic [2*ADDR_W-1:0] req_addr,
  output logic [1:0]          req_ready,
  output logic [1:0]          req_ack,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W+3:0]   mem_wdata,
  input  logic                mem_ready,
  output logic                busy
);
  state_t            state;
  logic              ptr, gid;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        grant;
  logic              accept;
  // pointed requester wins a tie; a lone requester wins regardless
  always_comb begin
    grant = (&req_valid) ? (ptr ? 2'b10 : 2'b01) : req_valid;
  end
  assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign busy      = state != IDLE;
  assign mem_we    = state == WRITE;
  // control FSM: arbitration, latch, shift count, write handshake and ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      gid     <= 1'b0;
      cnt     <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      req_ack <= 2'b00;
    end else begin
      req_ack <= 2'b00;
      case (state)
        IDLE: if (accept) begin
          state  <= LOAD;
          gid    <= req_ready[1];
          ptr    <= !req_ready[1];
          data_q <= req_ready[1] ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
          addr_q <= req_ready[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        end
        LOAD: begin
          state <= SHIFT;
          cnt   <= '0;
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= WRITE;
        end
        WRITE: if (mem_ready) begin
          state   <= IDLE;
          req_ack <= gid ? 2'b10 : 2'b01;
        end
        default: state <= IDLE;
      endcase
    end
  end
  crc_code_encoder u_enc (
    .clk       (clk),
    .rst       (rst),
    .load      (state == LOAD),
    .shift_en  (state == SHIFT),
    .data      (data_q),
    .addr      (addr_q),
    .code_addr (mem_addr),
    .codeword  (mem_wdata)
  );
endmodule

// File: tb/tb_crc_encode_ctrl.sv
// tb_crc_encode_ctrl: randomized self-checking bench with a polynomial-division reference model
module tb_crc_encode_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [7:0]  req_addr;
  logic [1:0]  req_ready, req_ack;
  logic        mem_we, mem_ready, busy;
  logic [3:0]  mem_addr;
  logic [11:0] mem_wdata;
  int          n_vec = 0, n_bad = 0;
  logic        ptr_m;
  logic [1:0]  vld;
  logic [7:0]  dat[2];
  logic [3:0]  adr[2];

  crc_encode_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .req_ack   (req_ack),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // remainder of data(x) divided by x^4+x+1 by long division
  function automatic logic [3:0] crc_ref(input logic [7:0] d);
    logic [7:0] v = d;
    for (int i = 7; i >= 4; i--)
      if (v[i]) v = v ^ (8'h13 << (i - 4));
    return v[3:0];
  endfunction

  task automatic apply();
    req_valid = vld;
    req_data  = {dat[1], dat[0]};
    req_addr  = {adr[1], adr[0]};
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_ack"}, 32'(req_ack), 0);
    check({tag, "_we"}, 32'(mem_we), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_wdata"}, 32'(mem_wdata), 0);
  endtask

  // one full transaction starting at a negedge in IDLE; late raises the other requester mid-flight
  task automatic txn(input int stall, input bit late);
    int g, o, early;
    logic [7:0]  ed;
    logic [3:0]  ea;
    logic [11:0] cw;
    apply();
    #1;
    g = (vld == 2'b11) ? int'(ptr_m) : (vld[1] ? 1 : 0);
    o = 1 - g;
    check("grant", 32'(req_ready), 32'(2'b01 << g));
    check("busy_idle", 32'(busy), 0);
    ed = dat[g];
    ea = adr[g];
    cw = {ed, crc_ref(ed)};
    @(posedge clk);
    ptr_m = (g == 0);
    early = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("ack_pulse", 32'(req_ack), 0);
        check("ready_busy", 32'(req_ready), 0);
        check("busy", 32'(busy), 1);
      end
      if (k == 1 || k == 5) begin
        vld[g] = 1'b0;
        dat[g] = 8'($urandom);
        adr[g] = 4'($urandom);
      end
      if (late && k == 3 && !vld[o]) begin
        vld[o] = 1'b1;
        dat[o] = 8'($urandom);
        adr[o] = 4'($urandom);
      end
      if (late && k == 6) dat[o] = 8'($urandom);
      apply();
      early += int'(mem_we);
    end
    @(negedge clk);
    check("we_early", 32'(early), 0);
    check("we", 32'(mem_we), 1);
    check("addr", 32'(mem_addr), 32'(ea));
    check("wdata", 32'(mem_wdata), 32'(cw));
    check("ack_early", 32'(req_ack), 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_we", 32'(mem_we), 1);
      check("stall_addr", 32'(mem_addr), 32'(ea));
      check("stall_wdata", 32'(mem_wdata), 32'(cw));
      check("stall_ack", 32'(req_ack), 0);
    end
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    check("ack", 32'(req_ack), 32'(2'b01 << g));
    check("we_done", 32'(mem_we), 0);
    check("busy_done", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    vld = 2'b00;
    dat[0] = 8'h00; dat[1] = 8'h00;
    adr[0] = 4'h0;  adr[1] = 4'h0;
    ptr_m = 1'b0;
    apply();
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    // single requester, memory always ready
    vld = 2'b01; dat[0] = 8'hA5; adr[0] = 4'h3;
    txn(0, 1'b0);
    // simultaneous requests, then a repeat to see the pointer alternate
    vld = 2'b11; dat[0] = 8'hFF; adr[0] = 4'h1; dat[1] = 8'h10; adr[1] = 4'h2;
    txn(0, 1'b0);
    txn(1, 1'b0);
    vld = 2'b11; dat[0] = 8'h3C; adr[0] = 4'h7; dat[1] = 8'hC3; adr[1] = 4'h8;
    txn(2, 1'b0);
    txn(0, 1'b0);
    // memory stall of five cycles
    vld = 2'b01; dat[0] = 8'h5A; adr[0] = 4'hE;
    txn(5, 1'b0);
    // requester 1 arrives and changes its data while requester 0 is in flight
    vld = 2'b01; dat[0] = 8'h77; adr[0] = 4'h4;
    txn(1, 1'b1);
    txn(0, 1'b0);
    // reset in the middle of SHIFT discards the transaction
    vld = 2'b01; dat[0] = 8'hE7; adr[0] = 4'h9;
    apply();
    @(posedge clk);
    vld = 2'b10; dat[1] = 8'h99; adr[1] = 4'h6;
    repeat (6) @(negedge clk);
    apply();
    rst = 1'b1;
    #1;
    check_quiet("rst_mid");
    @(negedge clk);
    check_quiet("rst_hold");
    rst = 1'b0;
    ptr_m = 1'b0;
    vld = 2'b11; dat[0] = 8'h01; adr[0] = 4'h5;
    txn(0, 1'b0);
    txn(0, 1'b0);
    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 2; r++)
        if (!vld[r] && $urandom_range(1, 0) == 1) begin
          vld[r] = 1'b1;
          dat[r] = 8'($urandom);
          adr[r] = 4'($urandom);
        end
      if (vld == 2'b00) begin
        vld[$urandom_range(1, 0)] = 1'b1;
      end
      txn(int'($urandom_range(3, 0)), $urandom_range(1, 0) == 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
